// File: rtl/pac_pkg.sv
// Shared Pac-Man motion constants: direction codes, playfield geometry and
// the sequencer state encoding used by pac_mover.
package pac_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int STEP    = 8;
    localparam int X_SPAN  = 640;
    localparam int Y_MAX   = 472;
    localparam int START_X = 312;
    localparam int START_Y = 368;

    typedef enum logic [2:0] {
        IDLE,
        PROBE_REQ,
        WAIT_REQ,
        PROBE_CUR,
        WAIT_CUR,
        COMMIT
    } state_t;

endpackage

// File: rtl/pac_step.sv
// Combinational one-step lookahead: next tile position along a heading,
// with horizontal tunnel wrap and a vertical playfield-edge gate.
module pac_step #(
    parameter int STEP   = pac_pkg::STEP,
    parameter int X_SPAN = pac_pkg::X_SPAN,
    parameter int Y_MAX  = pac_pkg::Y_MAX
) (
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [1:0] dir,
    output logic [9:0] nx,
    output logic [8:0] ny,
    output logic       gate_blocked
);
    import pac_pkg::*;

    localparam logic [10:0] S  = 11'(STEP);
    localparam logic [10:0] XS = 11'(X_SPAN);
    localparam logic [10:0] YM = 11'(Y_MAX);

    logic [10:0] x11;
    logic [10:0] y11;

    assign x11 = {1'b0, x};
    assign y11 = {2'b00, y};

    // Arithmetic is done at 11 bits so the wrap compares cannot overflow.
    always_comb begin
        nx           = x;
        ny           = y;
        gate_blocked = 1'b0;
        case (dir)
            DIR_UP: begin
                ny           = 9'(y11 - S);
                gate_blocked = (y11 < S);
            end
            DIR_DOWN: begin
                ny           = 9'(y11 + S);
                gate_blocked = ((y11 + S) > YM);
            end
            DIR_LEFT: begin
                nx = (x11 < S) ? 10'(x11 + XS - S) : 10'(x11 - S);
            end
            default: begin
                nx = ((x11 + S) >= XS) ? 10'(x11 + S - XS) : 10'(x11 + S);
            end
        endcase
    end

endmodule

// File: rtl/pac_mover.sv
// Pac-Man motion sequencer: per movement tick, probes the requested heading,
// falls back to the current heading, and commits the first free one.
module pac_mover #(
    parameter int STEP    = pac_pkg::STEP,
    parameter int X_SPAN  = pac_pkg::X_SPAN,
    parameter int Y_MAX   = pac_pkg::Y_MAX,
    parameter int START_X = pac_pkg::START_X,
    parameter int START_Y = pac_pkg::START_Y,
    parameter int CHK_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [1:0] dir_req,
    input  logic       dir_req_valid,
    output logic [9:0] chk_x,
    output logic [8:0] chk_y,
    output logic [1:0] chk_dir,
    output logic       chk_valid,
    input  logic       chk_ok,
    output logic [9:0] pac_x,
    output logic [8:0] pac_y,
    output logic [1:0] pac_dir,
    output logic       moving,
    output logic       busy
);
    import pac_pkg::*;

    state_t     state, state_nx;
    logic [1:0] pend;
    logic [1:0] try_dir;
    logic       sel_cur;
    logic [1:0] lat_cnt;
    logic [1:0] snap_dir;
    logic [1:0] step_dir;
    logic [9:0] nx;
    logic [8:0] ny;
    logic       gate;
    logic       start, to_cur, stop, commit;

    // A request in the same cycle as the tick wins over the stored one.
    assign snap_dir = dir_req_valid ? dir_req : pend;
    assign step_dir = sel_cur ? pac_dir : try_dir;
    assign busy     = (state != IDLE);

    pac_step #(
        .STEP  (STEP),
        .X_SPAN(X_SPAN),
        .Y_MAX (Y_MAX)
    ) u_step (
        .x           (pac_x),
        .y           (pac_y),
        .dir         (step_dir),
        .nx          (nx),
        .ny          (ny),
        .gate_blocked(gate)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        chk_valid = 1'b0;
        start     = 1'b0;
        to_cur    = 1'b0;
        stop      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (move_tick) begin
                    start    = 1'b1;
                    state_nx = PROBE_REQ;
                end
            end
            PROBE_REQ: begin
                if (!gate) begin
                    chk_valid = 1'b1;
                    state_nx  = WAIT_REQ;
                end else if (try_dir == pac_dir) begin
                    stop     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    to_cur   = 1'b1;
                    state_nx = PROBE_CUR;
                end
            end
            WAIT_REQ: begin
                if (lat_cnt == 2'(CHK_LAT)) begin
                    if (chk_ok) begin
                        state_nx = COMMIT;
                    end else if (try_dir == pac_dir) begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        to_cur   = 1'b1;
                        state_nx = PROBE_CUR;
                    end
                end
            end
            PROBE_CUR: begin
                if (!gate) begin
                    chk_valid = 1'b1;
                    state_nx  = WAIT_CUR;
                end else begin
                    stop     = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_CUR: begin
                if (lat_cnt == 2'(CHK_LAT)) begin
                    if (chk_ok) begin
                        state_nx = COMMIT;
                    end else begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Query registers are loaded on entry to a probe so they are already
    // valid in the cycle chk_valid is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= DIR_LEFT;
            try_dir <= DIR_LEFT;
            sel_cur <= 1'b0;
            lat_cnt <= 2'd0;
            chk_x   <= 10'(START_X);
            chk_y   <= 9'(START_Y);
            chk_dir <= DIR_LEFT;
            pac_x   <= 10'(START_X);
            pac_y   <= 9'(START_Y);
            pac_dir <= DIR_LEFT;
            moving  <= 1'b0;
        end else begin
            if (dir_req_valid) pend <= dir_req;
            if (start) begin
                try_dir <= snap_dir;
                sel_cur <= 1'b0;
                chk_x   <= pac_x;
                chk_y   <= pac_y;
                chk_dir <= snap_dir;
            end
            if (to_cur) begin
                sel_cur <= 1'b1;
                chk_dir <= pac_dir;
            end
            if (state == PROBE_REQ || state == PROBE_CUR)
                lat_cnt <= 2'd1;
            else if (state == WAIT_REQ || state == WAIT_CUR)
                lat_cnt <= lat_cnt + 2'd1;
            if (stop) moving <= 1'b0;
            if (commit) begin
                pac_dir <= step_dir;
                pac_x   <= nx;
                pac_y   <= ny;
                moving  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pac_mover.sv
// Scoreboard bench for pac_mover: expected queries and tick results are
// queued by the stimulus and matched by an independent monitor.
module tb_pac_mover;
    import pac_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       move_tick = 1'b0;
    logic [1:0] dir_req = 2'b00;
    logic       dir_req_valid = 1'b0;
    logic       chk_ok = 1'b0;
    logic [9:0] chk_x, pac_x;
    logic [8:0] chk_y, pac_y;
    logic [1:0] chk_dir, pac_dir;
    logic       chk_valid, moving, busy;

    always #5 clk = ~clk;

    pac_mover #(.CHK_LAT(1)) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .dir_req(dir_req), .dir_req_valid(dir_req_valid),
        .chk_x(chk_x), .chk_y(chk_y), .chk_dir(chk_dir),
        .chk_valid(chk_valid), .chk_ok(chk_ok),
        .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
        .moving(moving), .busy(busy)
    );

    typedef struct { int x; int y; int dir; } query_t;
    typedef struct { int x; int y; int dir; int mv; int lat; } result_t;

    query_t  qexp[$];
    result_t rexp[$];
    bit      ok_q[$];

    int cyc = 0;
    int tick_cyc = 0;
    int n_checks = 0;
    int n_fails = 0;
    bit in_reset = 1'b1;
    bit ok_hold = 1'b0;
    int ex, ey;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void pushQ(input int x, input int y, input int d, input bit ok);
        query_t q;
        q.x = x; q.y = y; q.dir = d;
        qexp.push_back(q);
        ok_q.push_back(ok);
    endfunction

    function automatic void pushR(input int x, input int y, input int d, input int mv, input int lat);
        result_t r;
        r.x = x; r.y = y; r.dir = d; r.mv = mv; r.lat = lat;
        rexp.push_back(r);
    endfunction

    // Collision checker stand-in: answers each query one cycle later.
    initial begin
        bit armed = 1'b0;
        bit aval = 1'b0;
        forever begin
            @(negedge clk);
            chk_ok = ok_hold | (armed & aval);
            armed = 1'b0;
            if (chk_valid) begin
                armed = 1'b1;
                aval = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b0;
            end
        end
    end

    initial begin
        bit pb = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_valid) begin
                if (qexp.size() == 0) begin
                    checkOutput("unexpected_query", 1, 0);
                end else begin
                    query_t q;
                    q = qexp.pop_front();
                    checkOutput("query_x", 32'(chk_x), q.x);
                    checkOutput("query_y", 32'(chk_y), q.y);
                    checkOutput("query_dir", 32'(chk_dir), q.dir);
                end
            end
            if (pb && !busy && !in_reset) begin
                if (rexp.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    result_t r;
                    r = rexp.pop_front();
                    checkOutput("pac_x", 32'(pac_x), r.x);
                    checkOutput("pac_y", 32'(pac_y), r.y);
                    checkOutput("pac_dir", 32'(pac_dir), r.dir);
                    checkOutput("moving", 32'(moving), r.mv);
                    checkOutput("latency", cyc - tick_cyc, r.lat);
                end
            end
            pb = busy;
        end
    end

    task automatic request(input logic [1:0] d);
        @(negedge clk);
        dir_req = d;
        dir_req_valid = 1'b1;
        @(negedge clk);
        dir_req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] d, input bit with_req, input bit same_cycle, input bit extra_tick);
        int n;
        if (with_req && !same_cycle) request(d);
        @(negedge clk);
        move_tick = 1'b1;
        if (with_req && same_cycle) begin
            dir_req = d;
            dir_req_valid = 1'b1;
        end
        tick_cyc = cyc;
        @(negedge clk);
        move_tick = 1'b0;
        dir_req_valid = 1'b0;
        if (extra_tick) begin
            @(negedge clk);
            move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
        end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("busy_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkReset();
        checkOutput("rst_pac_x", 32'(pac_x), 312);
        checkOutput("rst_pac_y", 32'(pac_y), 368);
        checkOutput("rst_pac_dir", 32'(pac_dir), 2);
        checkOutput("rst_moving", 32'(moving), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_chk_valid", 32'(chk_valid), 0);
        checkOutput("rst_chk_x", 32'(chk_x), 312);
        checkOutput("rst_chk_y", 32'(chk_y), 368);
        checkOutput("rst_chk_dir", 32'(chk_dir), 2);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkReset();
        in_reset = 1'b0;

        // Pending left from reset, requested direction free.
        pushQ(312, 368, 2, 1); pushR(304, 368, 2, 1, 4);
        applyStimulus(DIR_LEFT, 0, 0, 0);
        // Up blocked, fall back to left.
        pushQ(304, 368, 0, 0); pushQ(304, 368, 2, 1); pushR(296, 368, 2, 1, 6);
        applyStimulus(DIR_UP, 1, 0, 0);
        // Up still pending; both blocked.
        pushQ(296, 368, 0, 0); pushQ(296, 368, 2, 0); pushR(296, 368, 2, 0, 5);
        applyStimulus(DIR_UP, 0, 0, 0);
        // Request coincides with the tick.
        pushQ(296, 368, 3, 1); pushR(304, 368, 3, 1, 4);
        applyStimulus(DIR_RIGHT, 1, 1, 0);
        // Second tick while busy must be dropped.
        pushQ(304, 368, 3, 1); pushR(312, 368, 3, 1, 4);
        applyStimulus(DIR_RIGHT, 0, 0, 1);

        ex = 312; ey = 368;
        for (int i = 0; i < 40; i++) begin
            pushQ(ex, ey, 3, 1); ex = ex + 8; pushR(ex, ey, 3, 1, 4);
            applyStimulus(DIR_RIGHT, 0, 0, 0);
        end
        pushQ(632, 368, 3, 1); pushR(0, 368, 3, 1, 4);
        applyStimulus(DIR_RIGHT, 0, 0, 0);
        pushQ(0, 368, 2, 1); pushR(632, 368, 2, 1, 4);
        applyStimulus(DIR_LEFT, 1, 0, 0);

        request(DIR_DOWN);
        for (int i = 0; i < 13; i++) begin
            pushQ(632, ey, 1, 1); ey = ey + 8; pushR(632, ey, 1, 1, 4);
            applyStimulus(DIR_DOWN, 0, 0, 0);
        end
        // At the bottom edge heading down: gated with no query.
        pushR(632, 472, 1, 0, 2);
        applyStimulus(DIR_DOWN, 0, 0, 0);
        pushQ(632, 472, 2, 1); pushR(624, 472, 2, 1, 4);
        applyStimulus(DIR_LEFT, 1, 0, 0);
        // Down gated, current heading left is queried instead.
        pushQ(624, 472, 2, 1); pushR(616, 472, 2, 1, 5);
        applyStimulus(DIR_DOWN, 1, 0, 0);

        ey = 472;
        request(DIR_UP);
        for (int i = 0; i < 59; i++) begin
            pushQ(616, ey, 0, 1); ey = ey - 8; pushR(616, ey, 0, 1, 4);
            applyStimulus(DIR_UP, 0, 0, 0);
        end
        pushR(616, 0, 0, 0, 2);
        applyStimulus(DIR_UP, 0, 0, 0);
        pushQ(616, 0, 2, 1); pushR(608, 0, 2, 1, 4);
        applyStimulus(DIR_LEFT, 1, 0, 0);

        // Reset while waiting on the checker, with chk_ok held high afterwards.
        request(DIR_RIGHT);
        pushQ(608, 0, 3, 1);
        @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        in_reset = 1'b1;
        rst = 1'b1;
        ok_hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ok_hold = 1'b0;
        @(negedge clk);
        checkReset();
        in_reset = 1'b0;
        // Pending must have returned to left.
        pushQ(312, 368, 2, 1); pushR(304, 368, 2, 1, 4);
        applyStimulus(DIR_LEFT, 0, 0, 0);

        repeat (10) @(negedge clk);
        checkOutput("query_queue_left", qexp.size(), 0);
        checkOutput("result_queue_left", rexp.size(), 0);
        checkOutput("answer_queue_left", ok_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
